// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder
//   Loop-back checker for a multiplexed, active-low 7-segment scan bus.
//   It waits for each digit dwell to become stable, decodes the glyph into
//   its slot, and publishes a 0..9999 reading once all four slots are
//   filled. It also flags error-glyph frames, unrecognised patterns and
//   loss of scan activity.
//
//   Optional feature macro: SEG7_SCAN_CONFIRM_EN
//     When defined, a completed frame publishes only if it matches the
//     previous completed frame. The first frame after reset or scan loss
//     only primes the comparison register.
//
// Ports
//   i_clk          system clock
//   i_reset_n      asynchronous active-low reset
//   i_seg[6:0]     cathodes {g,f,e,d,c,b,a}, active-low (0 = lit)
//   i_an[3:0]      anodes, active-low; [0] = ones, [3] = thousands
//   o_value[13:0]  last published reading
//   o_value_valid  one-cycle pulse per published frame
//   o_err_shown    last published frame held the E glyph
//   o_bad_glyph    last published frame held an unrecognised pattern
//   o_scan_lost    no capture for TIMEOUT_CYCLES cycles
// ---------------------------------------------------------------------------
module seg7_scan_decoder #(
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [6:0]  i_seg,
    input  logic [3:0]  i_an,
    output logic [13:0] o_value,
    output logic        o_value_valid,
    output logic        o_err_shown,
    output logic        o_bad_glyph,
    output logic        o_scan_lost
);

    // Counter widths: the stability counter tops out at STABLE_CYCLES-1,
    // the timeout counter saturates at TIMEOUT_CYCLES-1.
    localparam int unsigned STAB_W = $clog2(STABLE_CYCLES);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES);

    localparam logic [STAB_W-1:0] STAB_PRE  = STAB_W'(STABLE_CYCLES - 2);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_PRE    = TO_W'(TIMEOUT_CYCLES - 2);
    localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT_CYCLES - 1);

    // Slot type codes
    localparam logic [1:0] TYP_DIG = 2'd0;
    localparam logic [1:0] TYP_ERR = 2'd1;
    localparam logic [1:0] TYP_BAD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SETTLE   = 2'd1,
        S_CAPTURED = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [STAB_W-1:0]      r_stab_cnt;
    logic [STAB_W-1:0]      w_stab_nxt;
    logic                   w_capture;

    logic [3:0]             r_an_q;
    logic [6:0]             r_seg_q;
    logic                   w_same;

    logic [6:0]             w_lit;
    logic [3:0]             w_glyph_dig;
    logic [1:0]             w_glyph_typ;

    logic                   w_an_onehot;
    logic [1:0]             w_slot_idx;
    logic [3:0]             w_slot_bit;
    logic [3:0]             w_mask_cap;
    logic                   w_frame_done;

    logic [3:0][3:0]        r_dig;
    logic [3:0][1:0]        r_typ;
    logic [3:0]             r_mask;
    logic                   r_pub_pend;

    logic [TO_W-1:0]        r_to_cnt;
    logic                   w_to_hit;

    logic                   w_any_err;
    logic                   w_any_bad;
    logic [13:0]            w_value_dec;
    logic                   w_publish;

    logic [13:0]            r_value;
    logic                   r_value_valid;
    logic                   r_err_shown;
    logic                   r_bad_glyph;
    logic                   r_scan_lost;

    // Bus held identical to the previous cycle
    assign w_same = ({i_an, i_seg} == {r_an_q, r_seg_q});

    // Glyph decode on lit segments; anything outside the table is bad
    assign w_lit = ~i_seg;

    always_comb begin
        w_glyph_dig = 4'd0;
        w_glyph_typ = TYP_DIG;
        case (w_lit)
            7'h3F:   w_glyph_dig = 4'd0;
            7'h06:   w_glyph_dig = 4'd1;
            7'h5B:   w_glyph_dig = 4'd2;
            7'h4F:   w_glyph_dig = 4'd3;
            7'h66:   w_glyph_dig = 4'd4;
            7'h6D:   w_glyph_dig = 4'd5;
            7'h7D:   w_glyph_dig = 4'd6;
            7'h07:   w_glyph_dig = 4'd7;
            7'h7F:   w_glyph_dig = 4'd8;
            7'h6F:   w_glyph_dig = 4'd9;
            7'h00:   w_glyph_dig = 4'd0;   // leading blank reads as zero
            7'h79:   w_glyph_typ = TYP_ERR;
            default: w_glyph_typ = TYP_BAD;
        endcase
    end

    // Anode one-hot-low check and slot index
    always_comb begin
        w_an_onehot = 1'b1;
        w_slot_idx  = 2'd0;
        case (i_an)
            4'b1110: w_slot_idx = 2'd0;
            4'b1101: w_slot_idx = 2'd1;
            4'b1011: w_slot_idx = 2'd2;
            4'b0111: w_slot_idx = 2'd3;
            default: w_an_onehot = 1'b0;
        endcase
    end

    // Dwell FSM state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_stab_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_stab_cnt <= w_stab_nxt;
        end
    end

    // Dwell FSM next state; capture fires when the counter would reach
    // STABLE_CYCLES-1, i.e. after STABLE_CYCLES identical cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_stab_nxt  = r_stab_cnt;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stab_nxt = '0;
                if (w_an_onehot) begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (!w_an_onehot) begin
                    w_state_nxt = S_IDLE;
                    w_stab_nxt  = '0;
                end else if (!w_same) begin
                    w_stab_nxt  = '0;
                end else if (r_stab_cnt == STAB_PRE) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_CAPTURED;
                    w_stab_nxt  = STAB_LAST;
                end else begin
                    w_stab_nxt  = r_stab_cnt + STAB_W'(1);
                end
            end
            S_CAPTURED: begin
                if (!w_an_onehot) begin
                    w_state_nxt = S_IDLE;
                    w_stab_nxt  = '0;
                end else if (!w_same) begin
                    w_state_nxt = S_SETTLE;
                    w_stab_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_stab_nxt  = '0;
            end
        endcase
    end

    // Mask bookkeeping and timeout hit (a capture on the same cycle wins)
    assign w_slot_bit   = 4'b0001 << w_slot_idx;
    assign w_mask_cap   = r_mask | w_slot_bit;
    assign w_frame_done = w_capture && (w_mask_cap == 4'hF);
    assign w_to_hit     = !w_capture && (r_to_cnt == TO_PRE);

    // Frame content summary
    always_comb begin
        w_any_err = 1'b0;
        w_any_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (r_typ[i] == TYP_ERR) w_any_err = 1'b1;
            if (r_typ[i] == TYP_BAD) w_any_bad = 1'b1;
        end
    end

    assign w_value_dec = 14'(r_dig[3]) * 14'd1000 + 14'(r_dig[2]) * 14'd100
                       + 14'(r_dig[1]) * 14'd10   + 14'(r_dig[0]);

`ifdef SEG7_SCAN_CONFIRM_EN
    logic [3:0][3:0] r_cmp_dig;
    logic [3:0][1:0] r_cmp_typ;
    logic            r_cmp_valid;
    logic            w_match;

    assign w_match   = r_cmp_valid && (r_dig == r_cmp_dig) && (r_typ == r_cmp_typ);
    assign w_publish = r_pub_pend && w_match;

    // Comparison frame: primed by the first frame, replaced on mismatch,
    // forgotten on scan loss.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cmp_dig   <= '0;
            r_cmp_typ   <= '0;
            r_cmp_valid <= 1'b0;
        end else if (w_to_hit) begin
            r_cmp_valid <= 1'b0;
        end else if (r_pub_pend && !w_match) begin
            r_cmp_dig   <= r_dig;
            r_cmp_typ   <= r_typ;
            r_cmp_valid <= 1'b1;
        end
    end
`else
    assign w_publish = r_pub_pend;
`endif

    // Slots, mask, timeout counter and published outputs
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_an_q        <= 4'hF;
            r_seg_q       <= 7'h7F;
            r_dig         <= '0;
            r_typ         <= '0;
            r_mask        <= '0;
            r_pub_pend    <= 1'b0;
            r_to_cnt      <= '0;
            r_value       <= '0;
            r_value_valid <= 1'b0;
            r_err_shown   <= 1'b0;
            r_bad_glyph   <= 1'b0;
            r_scan_lost   <= 1'b0;
        end else begin
            r_an_q     <= i_an;
            r_seg_q    <= i_seg;
            r_pub_pend <= w_frame_done;

            if (w_capture) begin
                r_dig[w_slot_idx] <= w_glyph_dig;
                r_typ[w_slot_idx] <= w_glyph_typ;
                r_mask            <= w_frame_done ? 4'h0 : w_mask_cap;
            end else if (w_to_hit) begin
                r_mask <= 4'h0;
            end

            if (w_capture) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != TO_MAX) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end

            if (w_to_hit) begin
                r_scan_lost <= 1'b1;
            end

            r_value_valid <= 1'b0;
            if (w_publish) begin
                r_value_valid <= 1'b1;
                r_scan_lost   <= 1'b0;
                if (w_any_err) begin
                    r_err_shown <= 1'b1;
                    r_bad_glyph <= 1'b0;
                end else if (w_any_bad) begin
                    r_err_shown <= 1'b0;
                    r_bad_glyph <= 1'b1;
                end else begin
                    r_value     <= w_value_dec;
                    r_err_shown <= 1'b0;
                    r_bad_glyph <= 1'b0;
                end
            end
        end
    end

    assign o_value       = r_value;
    assign o_value_valid = r_value_valid;
    assign o_err_shown   = r_err_shown;
    assign o_bad_glyph   = r_bad_glyph;
    assign o_scan_lost   = r_scan_lost;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_decoder
//   Directed bench: a table of four-glyph frames with hand-computed
//   readings, plus sequences for dwell-length boundaries, anode ghosts,
//   mid-frame reset and scan loss/recovery.
// ---------------------------------------------------------------------------
module tb_seg7_scan_decoder;

    localparam int unsigned STABLE  = 16;
    localparam int unsigned TIMEOUT = 3000;
    localparam int          DWELL   = 100;
`ifdef SEG7_SCAN_CONFIRM_EN
    localparam int          FRAMES  = 2;
`else
    localparam int          FRAMES  = 1;
`endif

    // Active-low glyph patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] G0  = 7'h40;
    localparam logic [6:0] G1  = 7'h79;
    localparam logic [6:0] G2  = 7'h24;
    localparam logic [6:0] G3  = 7'h30;
    localparam logic [6:0] G4  = 7'h19;
    localparam logic [6:0] G5  = 7'h12;
    localparam logic [6:0] G6  = 7'h02;
    localparam logic [6:0] G7  = 7'h78;
    localparam logic [6:0] G8  = 7'h00;
    localparam logic [6:0] G9  = 7'h10;
    localparam logic [6:0] GBL = 7'h7F;
    localparam logic [6:0] GE  = 7'h06;
    localparam logic [6:0] GX1 = 7'h7E;   // only 'a' lit
    localparam logic [6:0] GX2 = 7'h0F;   // e,f,g lit

    typedef struct packed {
        logic [6:0]  g3;
        logic [6:0]  g2;
        logic [6:0]  g1;
        logic [6:0]  g0;
        logic [13:0] exp_value;
        logic        exp_err;
        logic        exp_bad;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [13:0] o_value;
    logic        o_value_valid;
    logic        o_err_shown;
    logic        o_bad_glyph;
    logic        o_scan_lost;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   vv_cnt   = 0;
    int   vv0;
    vec_t vecs [9];

    always #5 clk = ~clk;

    seg7_scan_decoder #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_seg         (seg),
        .i_an          (an),
        .o_value       (o_value),
        .o_value_valid (o_value_valid),
        .o_err_shown   (o_err_shown),
        .o_bad_glyph   (o_bad_glyph),
        .o_scan_lost   (o_scan_lost)
    );

    // Count publish pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (o_value_valid) vv_cnt <= vv_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one bus pattern for n clock cycles (inputs change just after posedge)
    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One scan pass an[0]..an[3]; optional 3-cycle all-lit ghost on each switch
    task automatic scan_frame(input logic [6:0] g3, input logic [6:0] g2,
                              input logic [6:0] g1, input logic [6:0] g0,
                              input int dwell, input bit ghost);
        logic [6:0] g [4];
        logic [3:0] a;
        g[0] = g0;
        g[1] = g1;
        g[2] = g2;
        g[3] = g3;
        for (int i = 0; i < 4; i++) begin
            a = ~(4'b0001 << i);
            if (ghost) hold(a, 7'h00, 3);
            hold(a, g[i], dwell);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [13:0] value,
                                 input logic err, input logic bad, input logic lost);
        check({tag, " value"},     32'(o_value),     32'(value));
        check({tag, " err_shown"}, 32'(o_err_shown), 32'(err));
        check({tag, " bad_glyph"}, 32'(o_bad_glyph), 32'(bad));
        check({tag, " scan_lost"}, 32'(o_scan_lost), 32'(lost));
    endtask

    initial begin
        vecs[0] = '{G1,  G2,  G3,  G4,  14'd1234, 1'b0, 1'b0};
        vecs[1] = '{GE,  G5,  G6,  G7,  14'd1234, 1'b1, 1'b0};
        vecs[2] = '{GBL, GBL, G4,  G2,  14'd42,   1'b0, 1'b0};
        vecs[3] = '{G1,  GX1, G3,  G4,  14'd42,   1'b0, 1'b1};
        vecs[4] = '{GE,  GX2, G8,  G9,  14'd42,   1'b1, 1'b0};
        vecs[5] = '{G9,  G0,  G5,  G8,  14'd9058, 1'b0, 1'b0};
        vecs[6] = '{G0,  G0,  G0,  G0,  14'd0,    1'b0, 1'b0};
        vecs[7] = '{G6,  G7,  G8,  G9,  14'd6789, 1'b0, 1'b0};
        vecs[8] = '{GBL, GBL, GBL, GBL, 14'd0,    1'b0, 1'b0};

        // Reset state
        reset_n = 1'b0;
        an      = 4'hF;
        seg     = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset", 14'd0, 1'b0, 1'b0, 1'b0);
        check("reset value_valid", 32'(o_value_valid), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Frame table
        for (int v = 0; v < 9; v++) begin
            vv0 = vv_cnt;
            repeat (FRAMES) scan_frame(vecs[v].g3, vecs[v].g2, vecs[v].g1, vecs[v].g0, DWELL, 1'b0);
            check($sformatf("vec%0d pulses", v), 32'(vv_cnt - vv0), 32'd1);
            check_outputs($sformatf("vec%0d", v), vecs[v].exp_value, vecs[v].exp_err,
                          vecs[v].exp_bad, 1'b0);
        end

        // Dwell one cycle short of STABLE never captures
        vv0 = vv_cnt;
        scan_frame(G3, G3, G3, G3, STABLE - 1, 1'b0);
        hold(4'hF, 7'h7F, 20);
        check("short dwell pulses", 32'(vv_cnt - vv0), 32'd0);
        check("short dwell value", 32'(o_value), 32'd0);

        // Dwell of exactly STABLE cycles captures
        vv0 = vv_cnt;
        repeat (FRAMES) scan_frame(G1, G1, G1, G1, STABLE, 1'b0);
        hold(4'b0111, G1, 4);
        check("exact dwell pulses", 32'(vv_cnt - vv0), 32'd1);
        check("exact dwell value", 32'(o_value), 32'd1111);

        // Ghosts at each anode switch are filtered
        vv0 = vv_cnt;
        repeat (FRAMES) scan_frame(G5, G6, G7, G8, DWELL, 1'b1);
        check("ghost pulses", 32'(vv_cnt - vv0), 32'd1);
        check_outputs("ghost", 14'd5678, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-frame clears outputs before any clock edge
        hold(4'b1110, G1, DWELL);
        hold(4'b1101, G2, DWELL);
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs("midreset", 14'd0, 1'b0, 1'b0, 1'b0);
        check("midreset value_valid", 32'(o_value_valid), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Partial slots were discarded: two upper digits alone publish nothing
        vv0 = vv_cnt;
        hold(4'b1011, G9, DWELL);
        hold(4'b0111, G9, DWELL);
        check("post reset partial pulses", 32'(vv_cnt - vv0), 32'd0);
        hold(4'b1110, G9, DWELL);
        hold(4'b1101, G9, DWELL);
        repeat (FRAMES - 1) scan_frame(G9, G9, G9, G9, DWELL, 1'b0);
        check("post reset pulses", 32'(vv_cnt - vv0), 32'd1);
        check_outputs("post reset", 14'd9999, 1'b0, 1'b0, 1'b0);

        // Partial frame, then scan stops long enough to time out
        hold(4'b1011, G9, DWELL);
        hold(4'b0111, G9, DWELL);
        hold(4'hF, 7'h7F, TIMEOUT - 200);
        check("before timeout scan_lost", 32'(o_scan_lost), 32'd0);
        hold(4'hF, 7'h7F, 300);
        check("after timeout scan_lost", 32'(o_scan_lost), 32'd1);

        // Resume scanning "0007"
        vv0 = vv_cnt;
        scan_frame(G0, G0, G0, G7, DWELL, 1'b0);
`ifdef SEG7_SCAN_CONFIRM_EN
        check("resume prime pulses", 32'(vv_cnt - vv0), 32'd0);
        check("resume prime scan_lost", 32'(o_scan_lost), 32'd1);
        vv0 = vv_cnt;
        scan_frame(G0, G0, G0, G7, DWELL, 1'b0);
`endif
        check("resume pulses", 32'(vv_cnt - vv0), 32'd1);
        check_outputs("resume", 14'd7, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side counterpart of the multiplexed 7-segment display drivers in the reaction-time design. It samples the active-low `seg`/`an` scan bus, filters anode-switching ghosts, and rebuilds the four displayed digits into a binary millisecond value. It also reports error-glyph frames, corrupt frames and loss of scan activity. It sits beside the display outputs as a loop-back checker for the bench and for on-board self-test.

## Interface
- `STABLE_CYCLES`, 16: consecutive cycles `an`/`seg` must hold unchanged before a digit is captured (≥2).
- `TIMEOUT_CYCLES`, 1_000_000: cycles without any capture before `scan_lost` asserts.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `seg` in 7: cathodes `{g,f,e,d,c,b,a}`, active-low (0 = lit).
- `an` in 4: anodes, active-low; `an[0]` = ones digit, `an[3]` = thousands.
- `value` out 14: last published reading, 0..9999.
- `value_valid` out 1: one-cycle pulse per completed frame.
- `err_shown` out 1: last frame contained the `E` glyph.
- `bad_glyph` out 1: last frame contained an unrecognised pattern.
- `scan_lost` out 1: no capture for `TIMEOUT_CYCLES` cycles.

## Operation
- Glyph table (lit segments):
  - 0 abcdef; 1 bc; 2 abdeg; 3 abcdg; 4 bcfg; 5 acdfg; 6 acdefg; 7 abc; 8 abcdefg; 9 abcdfg.
  - Blank (none lit) decodes as 0 (leading-blank digits).
  - `E` adefg is the error glyph.
  - Any other pattern is bad.
- Per-dwell FSM:
  - IDLE: `an` not one-hot-low. Counter held at 0.
  - SETTLE: `an` is one-hot-low. Counter increments while `{an,seg}` equals the previous cycle. Any change restarts the counter at 0, and a non-one-hot `an` returns the FSM to IDLE.
  - SETTLE→CAPTURED: on the cycle the counter reaches `STABLE_CYCLES-1`. That cycle writes the digit slot and type (digit/E/bad) and sets the slot's bit in a 4-bit mask.
  - CAPTURED: no further capture. Any change on `{an,seg}` goes to SETTLE with the counter at 0, or to IDLE if `an` is not one-hot-low.
- A repeated capture of a slot before the frame completes overwrites that slot.
- When the mask reaches 4'b1111, the frame is published and the mask is cleared:
  - Any `E`: `err_shown`=1, `bad_glyph`=0, `value` unchanged.
  - Else any bad: `bad_glyph`=1, `err_shown`=0, `value` unchanged.
  - Else: `value` = d3·1000 + d2·100 + d1·10 + d0, with 14-bit unsigned result and no overflow possible; `err_shown`=`bad_glyph`=0.
  - `value_valid` pulses for every published frame.
- `scan_lost`:
  - A timeout counter runs while no capture occurs; any capture resets it to 0.
  - `scan_lost` sets on the cycle the counter reaches `TIMEOUT_CYCLES-1` and also clears the mask.
  - It clears on the next publish.
  - The counter saturates.

## Timing
- Reset values: `value`=0, `value_valid`=0, `err_shown`=0, `bad_glyph`=0, `scan_lost`=0. Mask, slots and counters are cleared and the FSM is in IDLE.
- Capture latency: a stable dwell starting at cycle t (first cycle of new `{an,seg}`) captures at the rising edge ending cycle t+`STABLE_CYCLES`-1.
- Publish latency: `value`, flags and `value_valid` are registered one cycle after the capture that completes the mask.
- Dwells shorter than `STABLE_CYCLES` cycles never capture.
- If a capture and the timeout fall on the same cycle, the capture wins: the counter resets and `scan_lost` does not set.
- `reset_n` asserted mid-frame discards partial slots immediately, without waiting for a clock edge.

## Configuration
- Feature macro: `SEG7_SCAN_CONFIRM_EN`.
  - Defined: a frame publishes only if all four slot types and values equal those of the previous completed frame; the first frame after reset or after `scan_lost` only primes the comparison register. A mismatch replaces the comparison frame, and that completion produces no `value_valid` and no flag changes.
  - Undefined: every completed frame publishes, and no comparison register is built.

## Test plan
- Scan "1234", dwell 100 cycles/digit → `value_valid` once per frame, `value`=1234, flags 0.
- Scan blank/blank/"4"/"2" (d3..d0) → `value`=42.
- Scan "E" on `an[3]`, valid digits elsewhere, after a prior 1234 → `err_shown`=1, `value` stays 1234.
- Insert a 3-cycle ghost pattern 0x00 at each anode switch (`STABLE_CYCLES`=16) → ghosts ignored, `value`=5678, `bad_glyph`=0.
- Stop scanning (`an`=4'hF) for `TIMEOUT_CYCLES` → `scan_lost`=1. Resume scanning "0007" → `scan_lost`=0, `value`=7. With `SEG7_SCAN_CONFIRM_EN`, publish on the second frame only.
- Assert `reset_n`=0 after 2 digits captured → all outputs 0. After release, a full "9999" frame gives `value`=9999.
